tv80_alu16_seq: RTL

- Multi-cycle sequencer that drives the 8-bit tv80_alu to perform 16-bit arithmetic: ADD HL,rr; ADC HL,rr; SBC HL,rr; ADD SP,e / LD HL,SP+e.
- Splits each request into a low-byte pass and a high-byte pass, and chains the carry and flags through the ALU's F_In/F_Out.
- Sits between the core's 16-bit datapath and the existing ALU. It is the initiator; the ALU is a combinational responder.

---
 rtl/tv80_alu16_pkg.sv | 32 +++
 rtl/tv80_alu.sv | 50 +++++
 rtl/tv80_alu16_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/tv80_alu16_pkg.sv
// Shared types and constants for the 16-bit arithmetic sequencer around tv80_alu.
// Holds the op and state enums, the flag bit positions and the ALU operation codes.
package tv80_alu16_pkg;

   typedef enum logic [1:0] {
      ADD16 = 2'b00,
      ADC16 = 2'b01,
      SBC16 = 2'b10,
      ADDSP = 2'b11
   } op16_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LO   = 2'b01,
      HI   = 2'b10
   } state_t;

   localparam int FLAG_C = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_P = 2;
   localparam int FLAG_X = 3;
   localparam int FLAG_H = 4;
   localparam int FLAG_Y = 5;
   localparam int FLAG_Z = 6;
   localparam int FLAG_S = 7;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_ADC = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_SBC = 4'd3;

endpackage

// File: rtl/tv80_alu.sv
// Combinational 8-bit ALU, add/subtract group only (ops 0-3); other codes pass bus_a and f_in through.
// Zero latency, no backpressure; z16 chains the zero flag, arith16 preserves S/Z/P.
module tv80_alu
   import tv80_alu16_pkg::*;
(
   input  logic [3:0] alu_op,
   input  logic       arith16,
   input  logic       z16,
   input  logic [7:0] bus_a,
   input  logic [7:0] bus_b,
   input  logic [7:0] f_in,
   output logic [7:0] q,
   output logic [7:0] f_out
);

   logic       sub, cin;
   logic [7:0] bx;
   logic [4:0] s4;
   logic [7:0] s7;
   logic [8:0] s8;

   always_comb begin
      sub   = alu_op[1];
      cin   = sub ^ (alu_op[0] & f_in[FLAG_C]);
      bx    = sub ? ~bus_b : bus_b;
      s4    = {1'b0, bus_a[3:0]} + {1'b0, bx[3:0]} + {4'd0, cin};
      s7    = {1'b0, bus_a[6:0]} + {1'b0, bx[6:0]} + {7'd0, cin};
      s8    = {1'b0, bus_a} + {1'b0, bx} + {8'd0, cin};
      q     = bus_a;
      f_out = f_in;
      if (alu_op[3:2] == 2'b00) begin
         q              = s8[7:0];
         // Subtraction reports borrow, so invert the raw carries.
         f_out[FLAG_C]  = s8[8] ^ sub;
         f_out[FLAG_H]  = s4[4] ^ sub;
         f_out[FLAG_N]  = sub;
         f_out[FLAG_P]  = s8[8] ^ s7[7];
         f_out[FLAG_X]  = s8[3];
         f_out[FLAG_Y]  = s8[5];
         f_out[FLAG_S]  = s8[7];
         f_out[FLAG_Z]  = (s8[7:0] == 8'h00) ? (z16 ? f_in[FLAG_Z] : 1'b1) : 1'b0;
         if (arith16) begin
            f_out[FLAG_S] = f_in[FLAG_S];
            f_out[FLAG_Z] = f_in[FLAG_Z];
            f_out[FLAG_P] = f_in[FLAG_P];
         end
      end
   end

endmodule

// File: rtl/tv80_alu16_seq.sv
// 16-bit ADD/ADC/SBC/ADD SP,e as two byte passes through tv80_alu, chaining flags between passes.
// done pulses two cycles after start is taken; start is ignored while busy (no queueing).
module tv80_alu16_seq
   import tv80_alu16_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int FLAG_W   = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [15:0]         a,
   input  logic [15:0]         b,
   input  logic [FLAG_W-1:0]   f_in,
   output logic                busy,
   output logic                done,
   output logic [15:0]         result,
   output logic [FLAG_W-1:0]   f_out,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [7:0]          alu_bus_a,
   output logic [7:0]          alu_bus_b,
   output logic [FLAG_W-1:0]   alu_f_in,
   output logic                alu_arith16,
   output logic                alu_z16,
   input  logic [7:0]          alu_q,
   input  logic [FLAG_W-1:0]   alu_f_out
);

   state_t            state, state_nxt;
   op16_t             op_q;
   logic [15:0]       a_q, b_q;
   logic [FLAG_W-1:0] fi_q, lo_flags, final_flags;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         op_q     <= ADD16;
         a_q      <= '0;
         b_q      <= '0;
         fi_q     <= '0;
         lo_flags <= '0;
         result   <= '0;
         f_out    <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_q <= op16_t'(op);
               a_q  <= a;
               b_q  <= b;
               fi_q <= f_in;
            end
            LO: begin
               result[7:0] <= alu_q;
               lo_flags    <= alu_f_out;
            end
            HI: begin
               result[15:8] <= alu_q;
               f_out        <= final_flags;
               done         <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      alu_op      = ALU_ADD;
      alu_bus_a   = 8'h00;
      alu_bus_b   = 8'h00;
      alu_f_in    = '0;
      alu_arith16 = 1'b0;
      alu_z16     = 1'b0;
      final_flags = alu_f_out;
      case (state)
         IDLE: if (start) state_nxt = LO;
         LO: begin
            state_nxt   = HI;
            alu_bus_a   = a_q[7:0];
            alu_bus_b   = b_q[7:0];
            alu_f_in    = fi_q;
            alu_arith16 = (op_q == ADD16);
            case (op_q)
               ADC16:   alu_op = ALU_ADC;
               SBC16:   alu_op = ALU_SBC;
               default: alu_op = ALU_ADD;
            endcase
         end
         HI: begin
            state_nxt   = IDLE;
            alu_bus_a   = a_q[15:8];
            // The displacement e is signed, so its high byte is the sign extension.
            alu_bus_b   = (op_q == ADDSP) ? {8{b_q[7]}} : b_q[15:8];
            alu_f_in    = lo_flags;
            alu_arith16 = (op_q == ADD16);
            alu_z16     = (op_q == ADC16) || (op_q == SBC16);
            alu_op      = (op_q == SBC16) ? ALU_SBC : ALU_ADC;
            if (op_q == ADDSP) begin
               final_flags         = fi_q;
               final_flags[FLAG_Z] = 1'b0;
               final_flags[FLAG_N] = 1'b0;
               final_flags[FLAG_H] = lo_flags[FLAG_H];
               final_flags[FLAG_C] = lo_flags[FLAG_C];
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
